algo_t1_1r1w_bank_resp: RTL and testbench

ALGO_T1_1R1W_BANK_RESP -- requirements
Module: algo_t1_1r1w_bank_resp

---
 rtl/algo_t1_pkg.sv | 11 +
 rtl/algo_t1_rd_pipe.sv | 36 +++
 rtl/algo_t1_1r1w_bank_resp.sv | 121 ++++++++++++
 tb/tb_algo_t1_1r1w_bank_resp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_t1_pkg.sv
// Shared types and limits for the T1 1R1W bank with response pipeline.
package algo_t1_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned SRAM_DELAY_MAX = 4;

endpackage

// File: rtl/algo_t1_rd_pipe.sv
// Read-latency delay line: valid plus data, DEPTH stages, cleared by async reset.
module algo_t1_rd_pipe #(
  parameter int W     = 128,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld;
      r_data[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/algo_t1_1r1w_bank_resp.sv
// Single-bank 1R1W array: zero-fill sweep after reset, bit-masked writes,
// read-before-write reads returned after a fixed SRAM_DELAY latency.
module algo_t1_1r1w_bank_resp
  import algo_t1_pkg::*;
#(
  parameter int PHYWDTH    = 128,
  parameter int NUMSROW    = 4096,
  parameter int BITSROW    = 12,
  parameter int SRAM_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t1_writeA,
  input  logic [BITSROW-1:0] t1_addrA,
  input  logic [PHYWDTH-1:0] t1_dinA,
  input  logic [PHYWDTH-1:0] t1_bwA,
  input  logic               t1_readB,
  input  logic [BITSROW-1:0] t1_addrB,
  output logic [PHYWDTH-1:0] t1_doutB,
  output logic               t1_vldB,
  output logic               ready,
  output logic               addr_err
);

  localparam int AW = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;
  localparam logic [BITSROW:0] ROWS = (BITSROW+1)'(NUMSROW);
  // Out-of-range delays are clamped to the supported 1..SRAM_DELAY_MAX window.
  localparam int PIPE_DEPTH = (SRAM_DELAY < 1) ? 1 :
                              (SRAM_DELAY > int'(SRAM_DELAY_MAX)) ? int'(SRAM_DELAY_MAX) :
                              SRAM_DELAY;

  state_t             r_state;
  logic [BITSROW:0]   r_init_cnt;
  logic               r_ready;
  logic               r_addr_err;
  logic [PHYWDTH-1:0] r_mem [NUMSROW];

  logic               w_in_a;
  logic               w_in_b;
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic [PHYWDTH-1:0] w_wdata;
  logic [PHYWDTH-1:0] w_wmask;
  logic               w_rd_vld;
  logic [PHYWDTH-1:0] w_rd_data;

  assign w_in_a = ({1'b0, t1_addrA} < ROWS);
  assign w_in_b = ({1'b0, t1_addrB} < ROWS);

  // INIT owns the write port for the zero sweep; user writes only in READY.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_wmask = '0;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_we    = (r_init_cnt < ROWS);
        w_waddr = r_init_cnt[AW-1:0];
        w_wmask = '1;
      end else if (t1_writeA && w_in_a) begin
        w_we    = 1'b1;
        w_waddr = t1_addrA[AW-1:0];
        w_wdata = t1_dinA;
        w_wmask = t1_bwA;
      end
    end
  end

  // Array has no reset; contents are zeroed only by the INIT sweep.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= (r_mem[w_waddr] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  assign w_rd_vld  = (r_state == ST_READY) && t1_readB;
  assign w_rd_data = (w_rd_vld && w_in_b) ? r_mem[t1_addrB[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == ROWS) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if ((t1_writeA && !w_in_a) || (t1_readB && !w_in_b)) begin
            r_addr_err <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  algo_t1_rd_pipe #(
    .W     (PHYWDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_vld),
    .i_data (w_rd_data),
    .o_vld  (t1_vldB),
    .o_data (t1_doutB)
  );

  assign ready    = r_ready;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_algo_t1_1r1w_bank_resp.sv
// Scoreboard bench: three bank configurations, reads push expectations, negedge monitor pops.
module tb_algo_t1_1r1w_bank_resp;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        rst  [3];
  logic        wr   [3];
  logic        rd   [3];
  logic [4:0]  aA   [3];
  logic [4:0]  aB   [3];
  logic [31:0] din  [3];
  logic [31:0] bw   [3];
  logic [31:0] dout [3];
  logic        vld  [3];
  logic        rdy  [3];
  logic        err  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  algo_t1_1r1w_bank_resp #(.PHYWDTH(32), .NUMSROW(16), .BITSROW(5), .SRAM_DELAY(2)) u_a (
    .clk(clk), .rst(rst[0]), .t1_writeA(wr[0]), .t1_addrA(aA[0]), .t1_dinA(din[0]),
    .t1_bwA(bw[0]), .t1_readB(rd[0]), .t1_addrB(aB[0]), .t1_doutB(dout[0]),
    .t1_vldB(vld[0]), .ready(rdy[0]), .addr_err(err[0]));

  algo_t1_1r1w_bank_resp #(.PHYWDTH(32), .NUMSROW(16), .BITSROW(5), .SRAM_DELAY(3)) u_b (
    .clk(clk), .rst(rst[1]), .t1_writeA(wr[1]), .t1_addrA(aA[1]), .t1_dinA(din[1]),
    .t1_bwA(bw[1]), .t1_readB(rd[1]), .t1_addrB(aB[1]), .t1_doutB(dout[1]),
    .t1_vldB(vld[1]), .ready(rdy[1]), .addr_err(err[1]));

  algo_t1_1r1w_bank_resp #(.PHYWDTH(32), .NUMSROW(12), .BITSROW(5), .SRAM_DELAY(1)) u_c (
    .clk(clk), .rst(rst[2]), .t1_writeA(wr[2]), .t1_addrA(aA[2]), .t1_dinA(din[2]),
    .t1_bwA(bw[2]), .t1_readB(rd[2]), .t1_addrB(aB[2]), .t1_doutB(dout[2]),
    .t1_vldB(vld[2]), .ready(rdy[2]), .addr_err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dly(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + dly(k);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic do_wr(input int k, input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
    wr[k] = 1'b1; aA[k] = a; din[k] = d; bw[k] = m;
    step();
    wr[k] = 1'b0;
  endtask

  task automatic do_rd(input int k, input logic [4:0] a, input logic [31:0] e);
    rd[k] = 1'b1; aB[k] = a;
    push(k, e);
    step();
    rd[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 20 && qsize(k) > 0; i++) step();
    chk($sformatf("drain%0d", k), 32'(qsize(k)), 32'd0);
  endtask

  task automatic mon(input int k);
    exp_t e;
    if (rst[k] !== 1'b0) return;
    if (vld[k] === 1'b1) begin
      total++;
      if (qsize(k) == 0) begin
        bad++;
        $display("FAIL unexpected_vld%0d: got data %h with no read pending (cycle %0d)", k, dout[k], cyc);
      end else begin
        case (k)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        if (dout[k] !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL rdata%0d: got %h at cycle %0d want %h at cycle %0d", k, dout[k], cyc, e.data, e.due);
        end
      end
    end else begin
      chk($sformatf("idle_zero%0d", k), dout[k], 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; wr[k] = 1'b0; rd[k] = 1'b0;
      aA[k] = '0; aB[k] = '0; din[k] = '0; bw[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_vld%0d", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_dout%0d", k), dout[k], 32'd0);
      chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Requests during INIT must be ignored (row 5 write, out-of-range read).
    wr[0] = 1'b1; aA[0] = 5'd5; din[0] = 32'hFFFF_FFFF; bw[0] = 32'hFFFF_FFFF;
    rd[0] = 1'b1; aB[0] = 5'd20;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk($sformatf("init_ready_a_c%0d", i), 32'(rdy[0]), (i == 16) ? 32'd1 : 32'd0);
      if (i == 11 || i == 12)
        chk($sformatf("init_ready_c_c%0d", i), 32'(rdy[2]), (i == 12) ? 32'd1 : 32'd0);
    end
    wr[0] = 1'b0; rd[0] = 1'b0;
    chk("init_no_err", 32'(err[0]), 32'd0);

    do_rd(0, 5'd5, 32'd0);
    do_wr(0, 5'd3, 32'hFFFF_FFFF, 32'h00FF_FFFF);
    do_rd(0, 5'd3, 32'h00FF_FFFF);
    do_wr(0, 5'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wr[0] = 1'b1; aA[0] = 5'd7; din[0] = 32'h5A5A_5A5A; bw[0] = 32'hFFFF_FFFF;
    rd[0] = 1'b1; aB[0] = 5'd7;
    push(0, 32'hA5A5_A5A5);
    step();
    wr[0] = 1'b0;
    aB[0] = 5'd7;
    push(0, 32'h5A5A_5A5A);
    step();
    rd[0] = 1'b0;
    do_rd(0, 5'd15, 32'd0);
    drain(0);
    chk("a_no_err", 32'(err[0]), 32'd0);

    do_wr(1, 5'd0, 32'h1111_1111, 32'hFFFF_FFFF);
    do_wr(1, 5'd1, 32'h2222_2222, 32'hFFFF_FFFF);
    do_wr(1, 5'd2, 32'h3333_3333, 32'hFFFF_FFFF);
    rd[1] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      aB[1] = 5'(r);
      push(1, {8{4'(r + 1)}});
      step();
    end
    rd[1] = 1'b0;
    drain(1);

    rd[1] = 1'b1; aB[1] = 5'd1;
    step();
    aB[1] = 5'd2;
    step();
    rd[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    chk("midrst_vld", 32'(vld[1]), 32'd0);
    chk("midrst_ready", 32'(rdy[1]), 32'd0);
    step();
    step();
    rst[1] = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      step();
      chk($sformatf("reinit_ready_b_c%0d", i), 32'(rdy[1]), (i == 16) ? 32'd1 : 32'd0);
    end
    do_rd(1, 5'd1, 32'd0);
    drain(1);

    chk("c_err_clear", 32'(err[2]), 32'd0);
    do_rd(2, 5'd13, 32'd0);
    drain(2);
    chk("c_err_set", 32'(err[2]), 32'd1);
    do_wr(2, 5'd11, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    do_rd(2, 5'd11, 32'hDEAD_BEEF);
    drain(2);
    step();
    step();
    chk("c_err_held", 32'(err[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    chk("c_err_rst", 32'(err[2]), 32'd0);
    step();
    rst[2] = 1'b0;
    for (int i = 0; i < 20 && rdy[2] !== 1'b1; i++) step();
    chk("c_ready_again", 32'(rdy[2]), 32'd1);
    chk("c_err_after_init", 32'(err[2]), 32'd0);
    do_wr(2, 5'd12, 32'h1234_5678, 32'hFFFF_FFFF);
    chk("c_wr_oor_err", 32'(err[2]), 32'd1);
    do_rd(2, 5'd11, 32'd0);
    drain(2);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
